alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage directly upstream of the 32-bit ALU. Decodes the instruction fields into the ALU's 3-bit operation code and selects forwarded or immediate operands. It holds one instruction in a valid/ready pipeline register that drives the ALU's `a`, `b` and `alucontrol` inputs. It also provides stall back-pressure and a flush for branch redirect.

## Interface
- `XLEN`, 32, operand/result width
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded instruction fields present
- `in_ready`  out  1  stage can accept this cycle
- `opcode`  in  7  instruction[6:0]
- `funct3`  in  3  instruction[14:12]
- `funct7`  in  7  instruction[31:25]
- `rd_in`  in  5  destination register
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data
- `imm`  in  XLEN  sign-extended immediate
- `fwd_a_sel`, `fwd_b_sel`  in  2  00 regfile, 01 `mem_fwd`, 10 `wb_fwd`, 11 regfile
- `mem_fwd`, `wb_fwd`  in  XLEN  forwarded results
- `flush`  in  1  discard held and incoming instruction
- `out_valid`  out  1  ALU operands valid
- `out_ready`  in  1  downstream consumes this cycle
- `a`, `b`  out  XLEN  ALU operands
- `alucontrol`  out  3  ALU operation
- `rd_out`  out  5; `regwrite`, `memwrite`, `illegal`  out  1 each

## Operation
- ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL.
- Decode by opcode:
  - 0000011 load: ADD, b=imm, regwrite=1.
  - 0100011 store: ADD, b=imm, memwrite=1.
  - 1100011 branch: SUB, b=rs2, no write.
  - 0110011 R-type, b=rs2, regwrite=1:
    - funct7=0000001 with funct3=000: MUL.
    - funct7=0000001 with any other funct3: illegal.
    - funct3 000: funct7[5] ? SUB : ADD.
    - funct3 010: SLT; 110: OR; 111: AND.
    - any other funct3: illegal.
  - 0010011 I-type, b=imm, regwrite=1: funct3 000 ADD (never SUB), 010 SLT, 110 OR, 111 AND, other funct3 illegal.
  - Any other opcode: illegal.
- When `illegal`=1: alucontrol=000, regwrite=0, memwrite=0. The entry is still passed downstream so the trap logic can see it.
- Operand `a` = forward mux on rs1_data per `fwd_a_sel`.
- Operand `b`: imm for load, store and I-type. Otherwise the forward mux on rs2_data per `fwd_b_sel`.
- Forwarding is resolved combinationally in the capture cycle only. It is not re-evaluated while the entry is held.
- Single-entry register:
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - Load when `in_valid && in_ready`.
  - If no load and `out_ready`: out_valid→0.
- Flush has priority over everything: out_valid→0 next edge, and nothing is accepted that cycle.
- Data outputs hold their values when not loading, including after being drained.

## Timing
- Reset (async assert, sync release): out_valid=0, a=0, b=0, alucontrol=000, rd_out=0, regwrite=0, memwrite=0, illegal=0.
- Latency is 1 cycle: fields accepted at edge N appear on the outputs after edge N.
- Throughput is 1 per cycle when out_ready is held high. Simultaneous drain and load at the same edge replaces the entry with no bubble.
- While out_valid=1 and out_ready=0: all outputs are stable and in_ready=0.
- If flush coincides with out_ready=1 and in_valid=1: the held entry is dropped, the incoming beat is not accepted, and out_valid=0.
- If reset_n asserts mid-stall: outputs clear immediately, without waiting for a clock.

## Test plan
- Reset: reset_n=0 with random inputs → all outputs 0, in_ready=1 after release.
- Decode sweep with rs1=0x0000_0007, rs2=0x0000_0003, imm=0xFFFF_FFFC:
  - add → 010 b=3.
  - sub (funct7=0100000) → 110.
  - mul (funct7=0000001) → 011.
  - slti → 111 b=0xFFFF_FFFC.
  - sw → 010 memwrite=1 regwrite=0.
  - beq → 110.
  - opcode 1111111 → illegal=1 alucontrol=000.
- Forwarding: fwd_a_sel=01 with mem_fwd=0xDEAD_BEEF, and fwd_b_sel=10 with wb_fwd=0x1234_5678 on an R-type → a=0xDEAD_BEEF, b=0x1234_5678. For an I-type, b=imm regardless of fwd_b_sel.
- Back-pressure: 3 back-to-back adds with out_ready low for 2 cycles after the first → in_ready=0 during the stall, first entry held stable, all 3 delivered in order with no loss or duplication.
- Flush: flush=1 while an entry is held and in_valid=1 → out_valid=0 next cycle, incoming beat dropped. The next instruction is accepted normally after flush deasserts.
- Async reset mid-stall: reset_n pulsed low between edges with out_valid=1 → out_valid drops before the next clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 32-bit ALU: decodes opcode/funct fields into the ALU
// control code, resolves operand forwarding and holds one entry in a valid/ready register.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] mem_fwd,
  input  logic [XLEN-1:0] wb_fwd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      alucontrol,
  output logic [4:0]      rd_out,
  output logic            regwrite,
  output logic            memwrite,
  output logic            illegal
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011
  } opcode_e;

  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] memv,
    input logic [XLEN-1:0] wbv
  );
    case (sel)
      2'b01:   return memv;
      2'b10:   return wbv;
      default: return rf;
    endcase
  endfunction

  alu_op_e         w_alu;
  logic            w_regwrite;
  logic            w_memwrite;
  logic            w_illegal;
  logic            w_use_imm;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_load;

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  alu_op_e         r_alu;
  logic [4:0]      r_rd;
  logic            r_regwrite;
  logic            r_memwrite;
  logic            r_illegal;

  always_comb begin
    w_alu      = ALU_AND;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_illegal  = 1'b0;
    w_use_imm  = 1'b0;
    case (opcode)
      OP_LOAD: begin
        w_alu      = ALU_ADD;
        w_use_imm  = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_STORE: begin
        w_alu      = ALU_ADD;
        w_use_imm  = 1'b1;
        w_memwrite = 1'b1;
      end
      OP_BRANCH: w_alu = ALU_SUB;
      OP_RTYPE: begin
        w_regwrite = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (funct3 == 3'b000) w_alu = ALU_MUL;
          else                  w_illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  w_alu = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu = ALU_SLT;
            3'b110:  w_alu = ALU_OR;
            3'b111:  w_alu = ALU_AND;
            default: w_illegal = 1'b1;
          endcase
        end
      end
      OP_ITYPE: begin
        w_regwrite = 1'b1;
        w_use_imm  = 1'b1;
        case (funct3)
          3'b000:  w_alu = ALU_ADD;
          3'b010:  w_alu = ALU_SLT;
          3'b110:  w_alu = ALU_OR;
          3'b111:  w_alu = ALU_AND;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal entries still flow downstream for the trap logic, but must not write anything.
    if (w_illegal) begin
      w_alu      = ALU_AND;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
    end
  end

  assign w_a      = fwd_mux(fwd_a_sel, rs1_data, mem_fwd, wb_fwd);
  assign w_b      = w_use_imm ? imm : fwd_mux(fwd_b_sel, rs2_data, mem_fwd, wb_fwd);
  assign in_ready = !flush && (!r_valid || out_ready);
  assign w_load   = in_valid && in_ready;

  // Data fields only move on a load, so they hold after a drain or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_alu      <= ALU_AND;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_a        <= w_a;
      r_b        <= w_b;
      r_alu      <= w_alu;
      r_rd       <= rd_in;
      r_regwrite <= w_regwrite;
      r_memwrite <= w_memwrite;
      r_illegal  <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign a          = r_a;
  assign b          = r_b;
  assign alucontrol = r_alu;
  assign rd_out     = r_rd;
  assign regwrite   = r_regwrite;
  assign memwrite   = r_memwrite;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a behavioural
// model of the decode table and the single-entry hand-off register.
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      alu;
    logic [4:0]      rd;
    logic            rw;
    logic            mw;
    logic            ill;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, mem_fwd, wb_fwd;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a, b;
  logic [2:0]      alucontrol;
  logic [4:0]      rd_out;
  logic            regwrite, memwrite, illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t m;
  exp_t obs;
  logic [4:0] dut_q[$];

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd_in(rd_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alucontrol(alucontrol), .rd_out(rd_out),
    .regwrite(regwrite), .memwrite(memwrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb obs = {out_valid, a, b, alucontrol, rd_out, regwrite, memwrite, illegal};

  function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] rf);
    if (sel == 2'd1) return mem_fwd;
    if (sel == 2'd2) return wb_fwd;
    return rf;
  endfunction

  // Reference decode from the instruction table, using the current input fields.
  function automatic exp_t ref_entry();
    exp_t  e;
    string kind;
    string op;
    e = '0;
    case (opcode)
      7'b0000011: kind = "load";
      7'b0100011: kind = "store";
      7'b1100011: kind = "branch";
      7'b0110011: kind = "r";
      7'b0010011: kind = "i";
      default:    kind = "bad";
    endcase
    op = "bad";
    if (kind == "load" || kind == "store") op = "add";
    else if (kind == "branch") op = "sub";
    else if (kind == "r" && funct7 == 7'd1) op = (funct3 == 3'd0) ? "mul" : "bad";
    else if (kind == "r" || kind == "i") begin
      case (funct3)
        3'd0: op = (kind == "r" && funct7[5]) ? "sub" : "add";
        3'd2: op = "slt";
        3'd6: op = "or";
        3'd7: op = "and";
        default: op = "bad";
      endcase
    end
    case (op)
      "add": e.alu = 3'b010;
      "sub": e.alu = 3'b110;
      "mul": e.alu = 3'b011;
      "slt": e.alu = 3'b111;
      "or":  e.alu = 3'b001;
      default: e.alu = 3'b000;
    endcase
    e.ill = (op == "bad");
    e.rw  = !e.ill && (kind == "load" || kind == "r" || kind == "i");
    e.mw  = !e.ill && (kind == "store");
    e.v   = 1'b1;
    e.rd  = rd_in;
    e.a   = pick(fwd_a_sel, rs1_data);
    e.b   = (kind == "load" || kind == "store" || kind == "i") ? imm : pick(fwd_b_sel, rs2_data);
    return e;
  endfunction

  task automatic tick();
    logic rdy;
    rdy = !flush && (!m.v || out_ready);
    if (out_valid && out_ready && !flush) dut_q.push_back(rd_out);
    if (!reset_n)                 m = '0;
    else if (flush)               m.v = 1'b0;
    else if (in_valid && rdy)     m = ref_entry();
    else if (out_ready)           m.v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    case ($urandom_range(0, 6))
      0: opcode = 7'b0000011;
      1: opcode = 7'b0100011;
      2: opcode = 7'b1100011;
      3, 4: opcode = 7'b0110011;
      5: opcode = 7'b0010011;
      default: opcode = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: funct7 = 7'b0000000;
      1: funct7 = 7'b0100000;
      2: funct7 = 7'b0000001;
      default: funct7 = 7'($urandom);
    endcase
    funct3    = 3'($urandom);
    rd_in     = 5'($urandom);
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    imm       = $urandom;
    mem_fwd   = $urandom;
    wb_fwd    = $urandom;
    fwd_a_sel = 2'($urandom);
    fwd_b_sel = 2'($urandom);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    rand_fields();
    in_valid  = 1'b1;
    out_ready = 1'($urandom);
    flush     = 1'b0;
    m         = '0;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
    repeat (2) begin rand_fields(); @(posedge clk); #1; end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_hold got %h exp 0", obs); end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_decode();
    logic [6:0]  ops[7]   = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b1111111};
    logic [2:0]  f3s[7]   = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [6:0]  f7s[7]   = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    logic [2:0]  ealu[7]  = '{3'b010, 3'b110, 3'b011, 3'b111, 3'b010, 3'b110, 3'b000};
    logic [31:0] eb[7]    = '{32'd3, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd3, 32'd3};
    logic [2:0]  eflag[7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000, 3'b001};
    rs1_data = 32'd7; rs2_data = 32'd3; imm = 32'hFFFF_FFFC;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i]; funct3 = f3s[i]; funct7 = f7s[i]; rd_in = 5'(i + 1);
      tick();
      checks++;
      if ({out_valid, alucontrol, b, regwrite, memwrite, illegal} !== {1'b1, ealu[i], eb[i], eflag[i]})
        begin errors++; $display("FAIL decode_sweep[%0d] got v%b alu%b b%h f%b%b%b exp alu%b b%h f%b", i,
          out_valid, alucontrol, b, regwrite, memwrite, illegal, ealu[i], eb[i], eflag[i]); end
    end
    for (int i = 0; i < 60; i++) begin
      rand_fields();
      tick();
      checks++;
      if (obs !== m) begin errors++; $display("FAIL decode_rand[%0d] got %h exp %h", i, obs, m); end
    end
  endtask

  task automatic test_forwarding();
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0; rd_in = 5'd4;
    rs1_data = 32'h1111_1111; rs2_data = 32'h2222_2222; imm = 32'h55;
    mem_fwd = 32'hDEAD_BEEF; wb_fwd = 32'h1234_5678;
    fwd_a_sel = 2'b01; fwd_b_sel = 2'b10;
    tick();
    checks++;
    if ({a, b} !== {32'hDEAD_BEEF, 32'h1234_5678})
      begin errors++; $display("FAIL fwd_rtype got a=%h b=%h exp a=deadbeef b=12345678", a, b); end
    opcode = 7'b0010011;
    tick();
    checks++;
    if ({a, b} !== {32'hDEAD_BEEF, 32'h0000_0055})
      begin errors++; $display("FAIL fwd_itype got a=%h b=%h exp a=deadbeef b=00000055", a, b); end
  endtask

  task automatic test_back_to_back();
    exp_t held;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    tick();
    dut_q.delete();
    opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    in_valid = 1'b1; rd_in = 5'd1; rs1_data = 32'd10; rs2_data = 32'd1;
    tick();
    held = obs;
    checks++;
    if (obs !== m) begin errors++; $display("FAIL bp_first got %h exp %h", obs, m); end
    out_ready = 1'b0; rd_in = 5'd2; rs1_data = 32'd20;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      tick();
      checks++;
      if (obs !== held) begin errors++; $display("FAIL bp_stable[%0d] got %h exp %h", i, obs, held); end
    end
    out_ready = 1'b1;
    tick();
    rd_in = 5'd3; rs1_data = 32'd30;
    tick();
    checks++;
    if (obs !== m) begin errors++; $display("FAIL bp_third got %h exp %h", obs, m); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (dut_q.size() != 3 || dut_q[0] !== 5'd1 || dut_q[1] !== 5'd2 || dut_q[2] !== 5'd3)
      begin errors++; $display("FAIL bp_order got n=%0d %p exp 1,2,3", dut_q.size(), dut_q); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    opcode = 7'b0000011; funct3 = 3'd2; funct7 = 7'd0;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; rd_in = 5'd9;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1; rd_in = 5'd10;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    checks++;
    if (obs !== m || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_drop got %h exp %h", obs, m); end
    flush = 1'b0; rd_in = 5'd11;
    tick();
    checks++;
    if ({out_valid, rd_out} !== {1'b1, 5'd11})
      begin errors++; $display("FAIL flush_resume got v=%b rd=%0d exp v=1 rd=11", out_valid, rd_out); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; rd_in = 5'd21;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL async_setup got %b exp 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset got %h exp 0", obs); end
    #1 reset_n = 1'b1;
    m = '0;
    tick();
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      #1;
      exp_rdy = !flush && (!m.v || out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready[%0d] got %b exp %b", i, in_ready, exp_rdy); end
      tick();
      checks++;
      if (obs !== m) begin errors++; $display("FAIL rand_state[%0d] got %h exp %h", i, obs, m); end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_forwarding();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
